// File: rtl/fp16_addsub_seq.sv
// Sequential binary16 add/subtract: one alignment or normalisation shift per cycle.
// Flush-to-zero operands, truncating rounding, no inf/NaN handling.
module fp16_addsub_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 ovf
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 2;
    localparam int EW = EXP_W + 1;
    localparam logic [EXP_W-1:0] DIST_MAX = EXP_W'(MAN_W + 1);
    localparam logic [EW-1:0]    EXP_TOP  = EW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    big_man_q, big_man_d;
    logic [SW-1:0]    small_man_q, small_man_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic             big_sign_q, big_sign_d;
    logic             small_sign_q, small_sign_d;
    logic             sign_q, sign_d;
    logic [EW-1:0]    exp_q, exp_d;
    logic [EXP_W-1:0] dist_q, dist_d;
    logic [W-1:0]     result_q, result_d;
    logic             ovf_q, ovf_d;

    logic [W-1:0]     b_eff;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [SW-1:0]    man_a, man_b;
    logic [EW-1:0]    exp_inc, exp_dec;

    assign b_eff   = {b[W-1] ^ op, b[W-2:0]};
    assign exp_a   = a[W-2:MAN_W];
    assign exp_b   = b[W-2:MAN_W];
    assign man_a   = {2'b01, a[MAN_W-1:0]};
    assign man_b   = {2'b01, b[MAN_W-1:0]};
    assign exp_inc = exp_q + EW'(1);
    assign exp_dec = exp_q - EW'(1);

    always_comb begin
        state_d      = state_q;
        big_man_d    = big_man_q;
        small_man_d  = small_man_q;
        sum_d        = sum_q;
        big_sign_d   = big_sign_q;
        small_sign_d = small_sign_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        dist_d       = dist_q;
        result_d     = result_q;
        ovf_d        = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (exp_a == '0 || exp_b == '0) begin
                        result_d = (exp_b == '0) ? a : b_eff;
                        ovf_d    = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        // Operand with the larger exponent becomes the "big" one.
                        if (exp_a >= exp_b) begin
                            big_man_d    = man_a;
                            big_sign_d   = a[W-1];
                            small_man_d  = man_b;
                            small_sign_d = b_eff[W-1];
                            exp_d        = {1'b0, exp_a};
                            dist_d       = exp_a - exp_b;
                        end else begin
                            big_man_d    = man_b;
                            big_sign_d   = b_eff[W-1];
                            small_man_d  = man_a;
                            small_sign_d = a[W-1];
                            exp_d        = {1'b0, exp_b};
                            dist_d       = exp_b - exp_a;
                        end
                        state_d = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (dist_q == '0) begin
                    state_d = S_ADD;
                end else if (dist_q > DIST_MAX) begin
                    small_man_d = '0;
                    dist_d      = '0;
                end else begin
                    small_man_d = {1'b0, small_man_q[SW-1:1]};
                    dist_d      = dist_q - EXP_W'(1);
                end
            end
            S_ADD: begin
                if (big_sign_q == small_sign_q) begin
                    sum_d  = big_man_q + small_man_q;
                    sign_d = big_sign_q;
                end else if (big_man_q > small_man_q) begin
                    sum_d  = big_man_q - small_man_q;
                    sign_d = big_sign_q;
                end else if (big_man_q < small_man_q) begin
                    sum_d  = small_man_q - big_man_q;
                    sign_d = small_sign_q;
                end else begin
                    sum_d  = '0;
                    sign_d = 1'b0;
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (sum_q == '0) begin
                    result_d = '0;
                    ovf_d    = 1'b0;
                    state_d  = S_DONE;
                end else if (sum_q[SW-1]) begin
                    // Exponent is one bit wider than the field so exp-31 operands still overflow.
                    if (exp_inc >= EXP_TOP) begin
                        result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_inc[EXP_W-1:0], sum_q[MAN_W:1]};
                        ovf_d    = 1'b0;
                    end
                    state_d = S_DONE;
                end else if (sum_q[MAN_W]) begin
                    result_d = {sign_q, exp_q[EXP_W-1:0], sum_q[MAN_W-1:0]};
                    ovf_d    = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    sum_d = {sum_q[SW-2:0], 1'b0};
                    exp_d = exp_dec;
                    if (exp_dec == '0) begin
                        result_d = '0;
                        ovf_d    = 1'b0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            big_man_q    <= '0;
            small_man_q  <= '0;
            sum_q        <= '0;
            big_sign_q   <= 1'b0;
            small_sign_q <= 1'b0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            dist_q       <= '0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            big_man_q    <= big_man_d;
            small_man_q  <= small_man_d;
            sum_q        <= sum_d;
            big_sign_q   <= big_sign_d;
            small_sign_q <= small_sign_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            dist_q       <= dist_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign ovf    = ovf_q;
endmodule
